// File: rtl/sa_axi_burst_master.sv
// AXI4 burst self-test master: writes C_NUM_BURSTS incrementing bursts, reads them back and compares.
// Define SA_AXI_MST_PERF_EN to add the TXN_CYCLES run-length counter output.
module sa_axi_burst_master #(
    parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH   = 32'sd32,
    parameter int          C_M_AXI_DATA_WIDTH   = 32'sd32,
    parameter int          C_M_AXI_BURST_LEN    = 32'sd8,
    parameter int          C_NUM_BURSTS         = 32'sd4
) (
`ifdef SA_AXI_MST_PERF_EN
    output logic [31:0]                     TXN_CYCLES,
`endif
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int BYTES       = C_M_AXI_DATA_WIDTH / 32'sd8;
    localparam int BURST_BYTES = C_M_AXI_BURST_LEN * BYTES;
    localparam logic [7:0] LAST_BEAT  = 8'(C_M_AXI_BURST_LEN - 32'sd1);
    localparam logic [9:0] LAST_BURST = 10'(C_NUM_BURSTS - 32'sd1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_A   = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_BASE_ADDR);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] STRIDE_A = C_M_AXI_ADDR_WIDTH'(BURST_BYTES);

    if (C_M_AXI_DATA_WIDTH != 32'sd32 && C_M_AXI_DATA_WIDTH != 32'sd64 &&
        C_M_AXI_DATA_WIDTH != 32'sd128) begin : g_bad_width
        $error("sa_axi_burst_master: C_M_AXI_DATA_WIDTH must be 32, 64 or 128");
    end
    if (C_M_AXI_BURST_LEN < 32'sd1 || C_M_AXI_BURST_LEN > 32'sd256) begin : g_bad_len
        $error("sa_axi_burst_master: C_M_AXI_BURST_LEN must be 1..256");
    end
    if (BURST_BYTES > 32'sd4096) begin : g_bad_4k
        $error("sa_axi_burst_master: a burst must not exceed 4096 bytes");
    end
    if (C_NUM_BURSTS < 32'sd1 || C_NUM_BURSTS > 32'sd1024) begin : g_bad_num
        $error("sa_axi_burst_master: C_NUM_BURSTS must be 1..1024");
    end
    if ((C_M_TARGET_BASE_ADDR % BURST_BYTES) != 32'd0) begin : g_bad_base
        $error("sa_axi_burst_master: base address must be burst aligned");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                          state_r;
    logic                            init_q_r;
    logic                            rise_s;
    logic                            start_s;
    logic                            rd_err_s;
    logic                            last_beat_s;
    logic                            last_burst_s;
    logic [7:0]                      beat_r;
    logic [9:0]                      burst_r;
    logic [31:0]                     wval_r;
    logic [31:0]                     rexp_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   burst_addr_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r;
    logic [7:0]                      awlen_r;
    logic [7:0]                      arlen_r;
    logic                            awvalid_r;
    logic                            arvalid_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
    logic                            wlast_r;
    logic                            wvalid_r;
    logic                            bready_r;
    logic                            rready_r;
    logic                            txn_done_r;
    logic                            error_r;
    logic                            unused_ok_s;

    assign rise_s       = INIT_AXI_TXN & ~init_q_r;
    assign start_s      = rise_s & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign last_beat_s  = (beat_r == LAST_BEAT);
    assign last_burst_s = (burst_r == LAST_BURST);
    assign burst_addr_s = BASE_A + C_M_AXI_ADDR_WIDTH'(burst_r) * STRIDE_A;
    assign unused_ok_s  = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

    // Checks one accepted read beat: response code, data pattern and RLAST placement.
    always_comb begin
        rd_err_s = 1'b0;
        if (M_AXI_RRESP[1]) begin
            rd_err_s = 1'b1;
        end else if (M_AXI_RDATA != C_M_AXI_DATA_WIDTH'(rexp_r)) begin
            rd_err_s = 1'b1;
        end else if (M_AXI_RLAST != last_beat_s) begin
            rd_err_s = 1'b1;
        end else begin
            rd_err_s = 1'b0;
        end
    end

    // Run sequencer: write phase, read-back phase, and all registered channel outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            init_q_r   <= 1'b0;
            beat_r     <= 8'd0;
            burst_r    <= 10'd0;
            wval_r     <= 32'd0;
            rexp_r     <= 32'd0;
            awaddr_r   <= '0;
            araddr_r   <= '0;
            awlen_r    <= 8'd0;
            arlen_r    <= 8'd0;
            awvalid_r  <= 1'b0;
            arvalid_r  <= 1'b0;
            wdata_r    <= '0;
            wlast_r    <= 1'b0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            rready_r   <= 1'b0;
            txn_done_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            init_q_r <= INIT_AXI_TXN;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        txn_done_r <= 1'b0;
                        error_r    <= 1'b0;
                        beat_r     <= 8'd0;
                        burst_r    <= 10'd0;
                        wval_r     <= 32'd1;
                        rexp_r     <= 32'd1;
                        state_r    <= ST_WR_ADDR;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_WR_ADDR: begin
                    if (!awvalid_r) begin
                        awvalid_r <= 1'b1;
                        awaddr_r  <= burst_addr_s;
                        awlen_r   <= LAST_BEAT;
                    end else if (M_AXI_AWREADY) begin
                        awvalid_r <= 1'b0;
                        beat_r    <= 8'd0;
                        state_r   <= ST_WR_DATA;
                    end else begin
                        awvalid_r <= 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    // WVALID is low only on the first cycle of the state.
                    if (!wvalid_r) begin
                        wvalid_r <= 1'b1;
                        wdata_r  <= C_M_AXI_DATA_WIDTH'(wval_r);
                        wlast_r  <= last_beat_s;
                        wval_r   <= wval_r + 32'd1;
                    end else if (M_AXI_WREADY) begin
                        if (wlast_r) begin
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            beat_r   <= 8'd0;
                            bready_r <= 1'b1;
                            state_r  <= ST_WR_RESP;
                        end else begin
                            wdata_r <= C_M_AXI_DATA_WIDTH'(wval_r);
                            wval_r  <= wval_r + 32'd1;
                            wlast_r <= ((beat_r + 8'd1) == LAST_BEAT);
                            beat_r  <= beat_r + 8'd1;
                        end
                    end else begin
                        wvalid_r <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID && bready_r) begin
                        error_r  <= error_r | M_AXI_BRESP[1];
                        bready_r <= 1'b0;
                        if (last_burst_s) begin
                            burst_r <= 10'd0;
                            state_r <= ST_RD_ADDR;
                        end else begin
                            burst_r <= burst_r + 10'd1;
                            state_r <= ST_WR_ADDR;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RD_ADDR: begin
                    if (!arvalid_r) begin
                        arvalid_r <= 1'b1;
                        araddr_r  <= burst_addr_s;
                        arlen_r   <= LAST_BEAT;
                    end else if (M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        beat_r    <= 8'd0;
                        state_r   <= ST_RD_DATA;
                    end else begin
                        arvalid_r <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    // Burst end is counted locally so a missing RLAST cannot stall the run.
                    if (M_AXI_RVALID && rready_r) begin
                        error_r <= error_r | rd_err_s;
                        rexp_r  <= rexp_r + 32'd1;
                        if (last_beat_s) begin
                            rready_r <= 1'b0;
                            beat_r   <= 8'd0;
                            if (last_burst_s) begin
                                burst_r    <= 10'd0;
                                txn_done_r <= 1'b1;
                                state_r    <= ST_DONE;
                            end else begin
                                burst_r <= burst_r + 10'd1;
                                state_r <= ST_RD_ADDR;
                            end
                        end else begin
                            beat_r <= beat_r + 8'd1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SA_AXI_MST_PERF_EN
    logic [31:0] cycles_r;

    // Counts active run cycles, saturating rather than wrapping.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cycles_r <= 32'd0;
        end else if (start_s) begin
            cycles_r <= 32'd0;
        end else if ((state_r != ST_IDLE) && (state_r != ST_DONE) && (cycles_r != 32'hFFFF_FFFF)) begin
            cycles_r <= cycles_r + 32'd1;
        end else begin
            cycles_r <= cycles_r;
        end
    end

    assign TXN_CYCLES = cycles_r;
`endif

    assign TXN_DONE      = txn_done_r;
    assign ERROR         = error_r;
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWLEN   = awlen_r;
    assign M_AXI_AWSIZE  = 3'($clog2(BYTES));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARLEN   = arlen_r;
    assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_sa_axi_burst_master.sv
// Randomised bench for sa_axi_burst_master: memory-backed slave with stalls and fault injection,
// plus a second 64-bit/1-beat/2-burst instance on an always-ready slave.
module tb_sa_axi_burst_master;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- main instance (defaults: 32-bit, 8 beats, 4 bursts)
    logic        init = 1'b0, txn_done, error;
    logic [31:0] awaddr, araddr, wdata, rdata = 32'd0;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp = 2'd0, rresp = 2'd0;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
`ifdef SA_AXI_MST_PERF_EN
    logic [31:0] cycles;
`endif

    sa_axi_burst_master dut (
`ifdef SA_AXI_MST_PERF_EN
        .TXN_CYCLES(cycles),
`endif
        .ACLK(aclk), .ARESETN(aresetn), .INIT_AXI_TXN(init), .TXN_DONE(txn_done), .ERROR(error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // ---------------- second instance (64-bit, 1 beat, 2 bursts)
    logic        s6_init = 1'b0, s6_done, s6_error;
    logic [31:0] s6_awaddr, s6_araddr;
    logic [63:0] s6_wdata, s6_rdata = 64'd0;
    logic [7:0]  s6_awlen, s6_arlen, s6_wstrb;
    logic [2:0]  s6_awsize, s6_arsize;
    logic [1:0]  s6_awburst, s6_arburst;
    logic        s6_awvalid, s6_wlast, s6_wvalid, s6_bready, s6_arvalid, s6_rready;
    logic        s6_bvalid = 1'b0, s6_rvalid = 1'b0, s6_rlast = 1'b0;
`ifdef SA_AXI_MST_PERF_EN
    logic [31:0] s6_cycles;
`endif

    sa_axi_burst_master #(
        .C_M_AXI_DATA_WIDTH(64), .C_M_AXI_BURST_LEN(1), .C_NUM_BURSTS(2)
    ) dut6 (
`ifdef SA_AXI_MST_PERF_EN
        .TXN_CYCLES(s6_cycles),
`endif
        .ACLK(aclk), .ARESETN(aresetn), .INIT_AXI_TXN(s6_init), .TXN_DONE(s6_done), .ERROR(s6_error),
        .M_AXI_AWADDR(s6_awaddr), .M_AXI_AWLEN(s6_awlen), .M_AXI_AWSIZE(s6_awsize),
        .M_AXI_AWBURST(s6_awburst), .M_AXI_AWVALID(s6_awvalid), .M_AXI_AWREADY(1'b1),
        .M_AXI_WDATA(s6_wdata), .M_AXI_WSTRB(s6_wstrb), .M_AXI_WLAST(s6_wlast),
        .M_AXI_WVALID(s6_wvalid), .M_AXI_WREADY(1'b1), .M_AXI_BRESP(2'b00), .M_AXI_BVALID(s6_bvalid),
        .M_AXI_BREADY(s6_bready), .M_AXI_ARADDR(s6_araddr), .M_AXI_ARLEN(s6_arlen),
        .M_AXI_ARSIZE(s6_arsize), .M_AXI_ARBURST(s6_arburst), .M_AXI_ARVALID(s6_arvalid),
        .M_AXI_ARREADY(1'b1), .M_AXI_RDATA(s6_rdata), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(s6_rlast),
        .M_AXI_RVALID(s6_rvalid), .M_AXI_RREADY(s6_rready)
    );

    // ---------------- slave model for the main instance
    logic        slv_rst = 1'b1;
    bit          stall = 1'b0;
    int          bad_b = -1, bad_k = -1;
    int          aw_n, w_n, b_n, ar_n, r_n, r_idx, r_rem;
    bit          aw_wait, w_wait, ar_wait, b_pend, b_fired, r_fired;
    logic [31:0] aw_prev, ar_prev, w_prev;
    logic        wl_prev;
    logic [31:0] mem [0:31];

    function automatic logic rdy();
        return stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    endfunction

    task automatic slave_step();
        if (slv_rst) begin
            aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; r_idx = 0; r_rem = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_pend = 0; b_fired = 0; r_fired = 0;
            awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
            rlast = 1'b0; bresp = 2'd0; rdata = 32'd0;
        end else begin
            // address write
            if (aw_wait) begin
                check("aw_hold_valid", 64'(awvalid), 64'd1);
                check("aw_hold_addr", 64'(awaddr), 64'(aw_prev));
            end
            awready = rdy();
            aw_wait = 0;
            if (awvalid) begin
                if (awready) begin
                    check("awaddr", 64'(awaddr), 64'(BASE + 32'(aw_n * 32)));
                    check("awlen", 64'(awlen), 64'd7);
                    check("awsize", 64'(awsize), 64'd2);
                    check("awburst", 64'(awburst), 64'd1);
                    aw_n++;
                end else begin
                    aw_wait = 1; aw_prev = awaddr;
                end
            end
            // write data
            if (w_wait) begin
                check("w_hold_valid", 64'(wvalid), 64'd1);
                check("w_hold_data", 64'(wdata), 64'(w_prev));
                check("w_hold_last", 64'(wlast), 64'(wl_prev));
            end
            if (wvalid) check("w_after_aw", 64'(w_n < aw_n * 8), 64'd1);
            wready = rdy();
            w_wait = 0;
            if (wvalid) begin
                if (wready) begin
                    check("wdata", 64'(wdata), 64'(w_n + 1));
                    check("wlast", 64'(wlast), 64'((w_n % 8) == 7));
                    check("wstrb", 64'(wstrb), 64'hF);
                    if (w_n < 32) mem[w_n] = wdata;
                    w_n++;
                    if (w_n % 8 == 0) b_pend = 1;
                end else begin
                    w_wait = 1; w_prev = wdata; wl_prev = wlast;
                end
            end
            // write response
            if (b_fired) begin
                bvalid = 1'b0; bresp = 2'd0; b_fired = 0;
            end
            if (bready) check("bready_only_in_resp", 64'(b_pend), 64'd1);
            if (b_pend && !bvalid && rdy()) begin
                bvalid = 1'b1;
                bresp = (b_n == bad_b) ? 2'b10 : 2'b00;
            end
            if (bvalid && bready) begin
                b_fired = 1; b_pend = 0; b_n++;
            end
            // address read
            if (ar_wait) begin
                check("ar_hold_valid", 64'(arvalid), 64'd1);
                check("ar_hold_addr", 64'(araddr), 64'(ar_prev));
            end
            if (arvalid) check("ar_after_writes", 64'(b_n), 64'd4);
            arready = rdy();
            ar_wait = 0;
            if (arvalid) begin
                if (arready) begin
                    check("araddr", 64'(araddr), 64'(BASE + 32'(ar_n * 32)));
                    check("arlen", 64'(arlen), 64'd7);
                    check("arsize", 64'(arsize), 64'd2);
                    r_idx = ar_n * 8; r_rem = 8; ar_n++;
                end else begin
                    ar_wait = 1; ar_prev = araddr;
                end
            end
            // read data
            if (r_fired) begin
                r_idx++; r_rem--; r_n++; rvalid = 1'b0; rlast = 1'b0; r_fired = 0;
            end
            if (r_rem > 0 && !rvalid && rdy()) begin
                rvalid = 1'b1;
                rdata = ((r_idx < 32) ? mem[r_idx] : 32'd0) ^ ((r_idx == bad_k) ? 32'd1 : 32'd0);
                rlast = (r_rem == 1);
                rresp = 2'd0;
            end
            if (rvalid && rready) r_fired = 1;
        end
    endtask

    initial forever begin
        @(negedge aclk);
        slave_step();
    end

    // ---------------- always-ready slave for the second instance
    int aw6 = 0, w6 = 0, ar6 = 0, r6 = 0;
    bit b6_pend = 0, b6_fired = 0, r6_pend = 0, r6_fired = 0;

    initial forever begin
        @(negedge aclk);
        if (b6_fired) begin s6_bvalid = 1'b0; b6_fired = 0; end
        if (b6_pend && !s6_bvalid) s6_bvalid = 1'b1;
        if (s6_bvalid && s6_bready) begin b6_fired = 1; b6_pend = 0; end
        if (r6_fired) begin s6_rvalid = 1'b0; s6_rlast = 1'b0; r6_fired = 0; end
        if (r6_pend && !s6_rvalid) begin
            s6_rvalid = 1'b1; s6_rlast = 1'b1; s6_rdata = 64'(r6 + 1); r6++; r6_pend = 0;
        end
        if (s6_rvalid && s6_rready) r6_fired = 1;
        if (s6_awvalid) begin
            check("s6_awaddr", 64'(s6_awaddr), 64'(BASE + 32'(aw6 * 8)));
            check("s6_awlen", 64'(s6_awlen), 64'd0);
            check("s6_awsize", 64'(s6_awsize), 64'd3);
            aw6++;
        end
        if (s6_wvalid) begin
            check("s6_wdata", s6_wdata, 64'(w6 + 1));
            check("s6_wlast", 64'(s6_wlast), 64'd1);
            check("s6_wstrb", 64'(s6_wstrb), 64'hFF);
            w6++; b6_pend = 1;
        end
        if (s6_arvalid) begin
            check("s6_araddr", 64'(s6_araddr), 64'(BASE + 32'(ar6 * 8)));
            ar6++; r6_pend = 1;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_awvalid"}, 64'(awvalid), 64'd0);
        check({tag, "_wvalid"}, 64'(wvalid), 64'd0);
        check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        check({tag, "_bready"}, 64'(bready), 64'd0);
        check({tag, "_rready"}, 64'(rready), 64'd0);
        check({tag, "_awaddr"}, 64'(awaddr), 64'd0);
        check({tag, "_araddr"}, 64'(araddr), 64'd0);
        check({tag, "_awlen"}, 64'(awlen), 64'd0);
        check({tag, "_wdata"}, 64'(wdata), 64'd0);
        check({tag, "_wlast"}, 64'(wlast), 64'd0);
        check({tag, "_done"}, 64'(txn_done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(negedge aclk);
        init = 1'b0;
    endtask

    task automatic slave_reset();
        slv_rst = 1'b1;
        repeat (2) @(negedge aclk);
        slv_rst = 1'b0;
    endtask

    task automatic run(input string tag, input bit st, input int bb, input int bk,
                       input bit exp_err, input bit mid);
        int cyc;
        stall = st; bad_b = bb; bad_k = bk;
        slave_reset();
        pulse_init();
        check({tag, "_done_clear"}, 64'(txn_done), 64'd0);
        check({tag, "_err_clear"}, 64'(error), 64'd0);
        if (mid) begin
            cyc = 0;
            while (w_n < 10 && cyc < 5000) begin @(negedge aclk); cyc++; end
            pulse_init();
        end
        cyc = 0;
        while (!txn_done && cyc < 20000) begin @(negedge aclk); cyc++; end
        check({tag, "_done"}, 64'(txn_done), 64'd1);
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        repeat (3) @(negedge aclk);
        check({tag, "_done_held"}, 64'(txn_done), 64'd1);
        check({tag, "_aw_count"}, 64'(aw_n), 64'd4);
        check({tag, "_w_count"}, 64'(w_n), 64'd32);
        check({tag, "_b_count"}, 64'(b_n), 64'd4);
        check({tag, "_ar_count"}, 64'(ar_n), 64'd4);
        check({tag, "_r_count"}, 64'(r_n), 64'd32);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge aclk);
        check_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        slv_rst = 1'b0;

        run("basic", 1'b0, -1, -1, 1'b0, 1'b1);
        run("bresp_err", 1'b0, 1, -1, 1'b1, 1'b0);
        run("rdata_err", 1'b0, -1, 5, 1'b1, 1'b0);
        run("good_again", 1'b0, -1, -1, 1'b0, 1'b0);
        run("stall", 1'b1, -1, -1, 1'b0, 1'b1);
        run("stall_err", 1'b1, 2, 20, 1'b1, 1'b0);

        // asynchronous reset in the middle of burst 2 write data
        stall = 1'b0; bad_b = -1; bad_k = -1;
        slave_reset();
        pulse_init();
        cyc = 0;
        while (w_n < 18 && cyc < 5000) begin @(negedge aclk); cyc++; end
        check("rst_reached_burst2", 64'(w_n >= 18), 64'd1);
        #2 aresetn = 1'b0;
        #1 check_zero("async_rst");
        slv_rst = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        run("after_rst", 1'b0, -1, -1, 1'b0, 1'b0);

        // 64-bit, single-beat, two-burst instance
        s6_init = 1'b1;
        @(negedge aclk);
        s6_init = 1'b0;
        cyc = 0;
        while (!s6_done && cyc < 2000) begin @(negedge aclk); cyc++; end
        check("s6_done", 64'(s6_done), 64'd1);
        check("s6_error", 64'(s6_error), 64'd0);
        repeat (3) @(negedge aclk);
        check("s6_aw_count", 64'(aw6), 64'd2);
        check("s6_w_count", 64'(w6), 64'd2);
        check("s6_ar_count", 64'(ar6), 64'd2);
        check("s6_r_count", 64'(r6), 64'd2);
`ifdef SA_AXI_MST_PERF_EN
        begin
            logic [31:0] snap;
            check("s6_cycles_nonzero", 64'(s6_cycles != 32'd0), 64'd1);
            snap = s6_cycles;
            repeat (5) @(negedge aclk);
            check("s6_cycles_stable", 64'(s6_cycles), 64'(snap));
            check("main_cycles_nonzero", 64'(cycles != 32'd0), 64'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed no finish, required finish before 600000");
        $fatal(1, "watchdog expired");
    end

endmodule
